// File: rtl/pkg_cpu.sv
// -----------------------------------------------------------------------------
// pkg_cpu
// Definitions shared by the fetch stage and the instruction memory:
//   - ANCHO_PALABRA : datapath word width in bits
//   - TAM_MEM_BYTES : instruction memory size in bytes
//   - INSTR_NOP     : word placed in IF/ID when the slot carries no instruction
//   - estado_t      : fetch-stage state encoding
//   - es_alineada() : true when a byte address is on a 4-byte boundary
// -----------------------------------------------------------------------------
package pkg_cpu;

  localparam int          ANCHO_PALABRA = 32;
  localparam int          TAM_MEM_BYTES = 256;
  localparam logic [31:0] INSTR_NOP     = 32'h0000_0000;

  typedef enum logic [1:0] {
    ARRANQUE = 2'd0,
    FETCH    = 2'd1,
    DETENIDO = 2'd2,
    ERROR    = 2'd3
  } estado_t;

  function automatic logic es_alineada(input logic [31:0] dir);
    return (dir[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/reg_if_id.sv
// -----------------------------------------------------------------------------
// reg_if_id
// IF/ID pipeline register. Flush has priority over enable, so a redirect
// empties the slot even while the hazard unit is stalling.
//   clk, reset      : clock, synchronous active-high reset
//   i_en            : load new slot (driven from !stall by the fetch stage)
//   i_flush         : invalidate slot (instruction becomes INSTR_NOP)
//   i_pc, i_instr   : PC and fetched word to capture
//   o_pc_id         : PC of the instruction held
//   o_pc_mas4_id    : o_pc_id + 4
//   o_instr_id      : instruction held
//   o_valido_id     : slot holds a real instruction
// -----------------------------------------------------------------------------
module reg_if_id
  import pkg_cpu::*;
#(
  parameter logic [31:0] NOP = pkg_cpu::INSTR_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc_id,
  output logic [31:0] o_pc_mas4_id,
  output logic [31:0] o_instr_id,
  output logic        o_valido_id
);

  logic [31:0] r_pc_id;
  logic [31:0] r_pc_mas4_id;
  logic [31:0] r_instr_id;
  logic        r_valido_id;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_id      <= 32'h0000_0000;
      r_pc_mas4_id <= 32'h0000_0004;
      r_instr_id   <= NOP;
      r_valido_id  <= 1'b0;
    end else if (i_flush) begin
      // PC fields are left as they are; only the slot contents are killed.
      r_instr_id   <= NOP;
      r_valido_id  <= 1'b0;
    end else if (i_en) begin
      r_pc_id      <= i_pc;
      r_pc_mas4_id <= i_pc + 32'd4;
      r_instr_id   <= i_instr;
      r_valido_id  <= 1'b1;
    end
  end

  assign o_pc_id      = r_pc_id;
  assign o_pc_mas4_id = r_pc_mas4_id;
  assign o_instr_id   = r_instr_id;
  assign o_valido_id  = r_valido_id;

endmodule

// File: rtl/etapa_fetch.sv
// -----------------------------------------------------------------------------
// etapa_fetch
// Instruction fetch stage. Owns the PC, drives the instruction memory address
// combinationally from it and captures the returned word into IF/ID at the
// same edge (zero-latency memory).
//   clk, reset        : clock, synchronous active-high reset
//   stall             : hold PC and IF/ID
//   salto_tomado      : redirect request
//   destino_salto     : redirect target byte address
//   direccion         : instruction memory address (= PC register)
//   instruccion       : word returned by the memory for direccion
//   pc_id, pc_mas4_id : PC and PC+4 of the instruction in IF/ID
//   instruccion_id    : instruction in IF/ID
//   valido_id         : IF/ID holds a real instruction
//   detenido          : stage halted (DETENIDO or ERROR)
//   error_alineacion  : sticky, a misaligned redirect was seen
// -----------------------------------------------------------------------------
module etapa_fetch
  import pkg_cpu::*;
#(
  parameter int          TAM_MEM   = pkg_cpu::TAM_MEM_BYTES,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] INSTR_NOP = pkg_cpu::INSTR_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        salto_tomado,
  input  logic [31:0] destino_salto,
  output logic [31:0] direccion,
  input  logic [31:0] instruccion,
  output logic [31:0] pc_id,
  output logic [31:0] pc_mas4_id,
  output logic [31:0] instruccion_id,
  output logic        valido_id,
  output logic        detenido,
  output logic        error_alineacion
);

  // Last legal fetch address; anything above it halts the stage.
  localparam logic [31:0] PC_LIMITE = 32'(TAM_MEM - 4);

  estado_t     r_estado;
  logic [31:0] r_pc;
  logic        r_error;

  estado_t     w_estado_sig;
  logic [31:0] w_pc_sig;
  logic        w_error_sig;
  logic        w_carga;
  logic        w_flush;
  logic        w_salto_ok;
  logic        w_salto_mal;

  assign w_salto_ok  = salto_tomado &&  es_alineada(destino_salto);
  assign w_salto_mal = salto_tomado && !es_alineada(destino_salto);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= ARRANQUE;
      r_pc     <= PC_RESET;
      r_error  <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      r_pc     <= w_pc_sig;
      r_error  <= w_error_sig;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_estado_sig = r_estado;
    w_pc_sig     = r_pc;
    w_error_sig  = r_error;
    w_carga      = 1'b0;
    w_flush      = 1'b0;

    unique case (r_estado)
      ARRANQUE: begin
        // Startup bubble: redirects and stalls are ignored, slot stays empty.
        w_flush      = 1'b1;
        w_estado_sig = FETCH;
      end

      FETCH: begin
        if (w_salto_mal) begin
          w_error_sig  = 1'b1;
          w_flush      = 1'b1;
          w_estado_sig = ERROR;
        end else if (w_salto_ok) begin
          // Redirect outranks stall: the wrong-path slot must die regardless.
          w_pc_sig = destino_salto;
          w_flush  = 1'b1;
        end else if (stall) begin
          // Hold everything.
        end else if (r_pc > PC_LIMITE) begin
          w_flush      = 1'b1;
          w_estado_sig = DETENIDO;
        end else begin
          w_carga  = 1'b1;
          w_pc_sig = r_pc + 32'd4;
        end
      end

      DETENIDO: begin
        if (w_salto_mal) begin
          w_error_sig  = 1'b1;
          w_flush      = 1'b1;
          w_estado_sig = ERROR;
        end else if (w_salto_ok) begin
          w_pc_sig     = destino_salto;
          w_flush      = 1'b1;
          w_estado_sig = FETCH;
        end else if (!stall) begin
          w_flush = 1'b1;
        end
      end

      ERROR: begin
        // Terminal until reset; keep the slot empty.
        w_flush = 1'b1;
      end

      default: begin
        w_flush      = 1'b1;
        w_estado_sig = ERROR;
      end
    endcase
  end

  reg_if_id #(
    .NOP (INSTR_NOP)
  ) u_reg_if_id (
    .clk          (clk),
    .reset        (reset),
    .i_en         (w_carga),
    .i_flush      (w_flush),
    .i_pc         (r_pc),
    .i_instr      (instruccion),
    .o_pc_id      (pc_id),
    .o_pc_mas4_id (pc_mas4_id),
    .o_instr_id   (instruccion_id),
    .o_valido_id  (valido_id)
  );

  assign direccion        = r_pc;
  assign detenido         = (r_estado == DETENIDO) || (r_estado == ERROR);
  assign error_alineacion = r_error;

endmodule

// File: tb/tb_etapa_fetch.sv
// -----------------------------------------------------------------------------
// tb_etapa_fetch
// Self-checking bench for etapa_fetch with a behavioural big-endian memory.
// Each valid IF/ID slot the stimulus expects is pushed to a scoreboard queue
// before the edge that should produce it; a negedge monitor pops and compares
// whenever a fresh valid slot appears. Directed checks cover PC, flush, halt,
// error and reset behaviour.
// -----------------------------------------------------------------------------
module tb_etapa_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } slot_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        salto_tomado;
  logic [31:0] destino_salto;
  logic [31:0] direccion;
  logic [31:0] instruccion;
  logic [31:0] pc_id;
  logic [31:0] pc_mas4_id;
  logic [31:0] instruccion_id;
  logic        valido_id;
  logic        detenido;
  logic        error_alineacion;

  logic [7:0]  mem [256];
  slot_t       sb_q [$];
  logic        stall_at_edge;
  logic        reset_at_edge;
  int          n_cmp;
  int          n_err;

  etapa_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .salto_tomado     (salto_tomado),
    .destino_salto    (destino_salto),
    .direccion        (direccion),
    .instruccion      (instruccion),
    .pc_id            (pc_id),
    .pc_mas4_id       (pc_mas4_id),
    .instruccion_id   (instruccion_id),
    .valido_id        (valido_id),
    .detenido         (detenido),
    .error_alineacion (error_alineacion)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word stored at each aligned address of the test program.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0: return 32'h1111_1111;
      32'h4: return 32'h2222_2222;
      32'h8: return 32'h3333_3333;
      default: return 32'hC0DE_0000 | a;
    endcase
  endfunction

  // Zero-latency big-endian instruction memory.
  always_comb begin
    logic [7:0] a;
    a = direccion[7:0];
    if (direccion < 32'd256)
      instruccion = {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    else
      instruccion = 32'hDEAD_DEAD;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    sb_q.push_back('{pc: a, instr: word_at(a)});
  endtask

  always @(posedge clk) begin
    stall_at_edge <= stall;
    reset_at_edge <= reset;
  end

  // A valid slot after an edge without stall or reset is a fresh fetch.
  always @(negedge clk) begin
    if (valido_id === 1'b1 && stall_at_edge === 1'b0 && reset_at_edge === 1'b0) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_slot", pc_id, 32'hFFFF_FFFF);
      end else begin
        slot_t e;
        e = sb_q.pop_front();
        check("sb_pc_id", pc_id, e.pc);
        check("sb_pc_mas4_id", pc_mas4_id, e.pc + 32'd4);
        check("sb_instruccion_id", instruccion_id, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i += 4) begin
      logic [31:0] w;
      w = word_at(32'(i));
      mem[i]     = w[31:24];
      mem[i + 1] = w[23:16];
      mem[i + 2] = w[15:8];
      mem[i + 3] = w[7:0];
    end
    reset         = 1'b1;
    stall         = 1'b0;
    salto_tomado  = 1'b0;
    destino_salto = 32'h0;

    // Reset state.
    step();
    step();
    check("rst_direccion", direccion, 32'h0);
    check("rst_pc_id", pc_id, 32'h0);
    check("rst_pc_mas4_id", pc_mas4_id, 32'h4);
    check("rst_instruccion_id", instruccion_id, 32'h0);
    check("rst_valido", 32'(valido_id), 32'd0);
    check("rst_detenido", 32'(detenido), 32'd0);
    check("rst_error", 32'(error_alineacion), 32'd0);

    // ARRANQUE bubble.
    reset = 1'b0;
    step();
    check("arranque_valido", 32'(valido_id), 32'd0);
    check("arranque_direccion", direccion, 32'h0);

    // Free run 0, 4.
    push(32'h0);
    step();
    push(32'h4);
    step();
    check("run_direccion", direccion, 32'h8);

    // Stall two cycles at pc=8.
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_direccion", direccion, 32'h8);
      check("stall_pc_id", pc_id, 32'h4);
      check("stall_instruccion_id", instruccion_id, 32'h2222_2222);
      check("stall_valido", 32'(valido_id), 32'd1);
    end
    stall = 1'b0;
    push(32'h8);
    step();
    check("resume_direccion", direccion, 32'hC);

    // Redirect together with stall: flush wins.
    salto_tomado  = 1'b1;
    destino_salto = 32'h40;
    stall         = 1'b1;
    step();
    salto_tomado = 1'b0;
    stall        = 1'b0;
    check("salto_direccion", direccion, 32'h40);
    check("salto_valido", 32'(valido_id), 32'd0);
    check("salto_instruccion_id", instruccion_id, 32'h0);
    push(32'h40);
    step();
    check("salto_next_direccion", direccion, 32'h44);

    // Run off the end of memory.
    salto_tomado  = 1'b1;
    destino_salto = 32'hF8;
    step();
    salto_tomado = 1'b0;
    push(32'hF8);
    step();
    push(32'hFC);
    step();
    check("fin_valido", 32'(valido_id), 32'd1);
    check("fin_direccion", direccion, 32'h100);
    check("fin_detenido_pre", 32'(detenido), 32'd0);
    step();
    check("halt_valido", 32'(valido_id), 32'd0);
    check("halt_detenido", 32'(detenido), 32'd1);
    check("halt_direccion", direccion, 32'h100);
    check("halt_instruccion_id", instruccion_id, 32'h0);
    step();
    check("halt_hold_detenido", 32'(detenido), 32'd1);

    // Redirect out of DETENIDO back to 0.
    salto_tomado  = 1'b1;
    destino_salto = 32'h0;
    step();
    salto_tomado = 1'b0;
    check("reanuda_detenido", 32'(detenido), 32'd0);
    check("reanuda_direccion", direccion, 32'h0);
    check("reanuda_valido", 32'(valido_id), 32'd0);
    push(32'h0);
    step();

    // Misaligned redirect -> ERROR.
    salto_tomado  = 1'b1;
    destino_salto = 32'h42;
    step();
    check("mal_error", 32'(error_alineacion), 32'd1);
    check("mal_detenido", 32'(detenido), 32'd1);
    check("mal_direccion", direccion, 32'h4);
    check("mal_valido", 32'(valido_id), 32'd0);
    destino_salto = 32'h80;
    step();
    salto_tomado = 1'b0;
    check("err_ignora_direccion", direccion, 32'h4);
    check("err_sticky", 32'(error_alineacion), 32'd1);
    check("err_detenido", 32'(detenido), 32'd1);

    // Reset clears ERROR.
    reset = 1'b1;
    step();
    check("rst2_error", 32'(error_alineacion), 32'd0);
    check("rst2_detenido", 32'(detenido), 32'd0);
    check("rst2_direccion", direccion, 32'h0);
    reset = 1'b0;
    step();

    // Reach pc=0x20 then reset mid-run.
    salto_tomado  = 1'b1;
    destino_salto = 32'h1C;
    step();
    salto_tomado = 1'b0;
    push(32'h1C);
    step();
    check("mid_direccion", direccion, 32'h20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_direccion", direccion, 32'h0);
    check("mid_rst_valido", 32'(valido_id), 32'd0);
    check("mid_rst_pc_id", pc_id, 32'h0);
    check("mid_rst_pc_mas4_id", pc_mas4_id, 32'h4);
    check("mid_rst_error", 32'(error_alineacion), 32'd0);
    // ARRANQUE: pc unchanged, slot still empty.
    step();
    check("mid_arranque_direccion", direccion, 32'h0);
    check("mid_arranque_valido", 32'(valido_id), 32'd0);
    push(32'h0);
    step();
    check("mid_fetch_direccion", direccion, 32'h4);

    @(negedge clk);
    #1;
    check("sb_pendientes", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
